// File: rtl/pmem_arbiter.sv
// pmem_arbiter: multi-channel line-memory arbiter, round-robin or fixed priority, one transaction at a time
module pmem_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int ARB_MODE   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_read,
    input  logic [NUM_CH-1:0]            ch_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_address,
    input  logic [NUM_CH*LINE_WIDTH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]            ch_resp,
    output logic [LINE_WIDTH-1:0]        ch_rdata,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [ADDR_WIDTH-1:0]        pmem_address,
    output logic [LINE_WIDTH-1:0]        pmem_wdata,
    input  logic                         pmem_resp,
    input  logic [LINE_WIDTH-1:0]        pmem_rdata
);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_next;
    logic [IW-1:0] grant, rr_ptr, sel;
    logic found, op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
    logic [NUM_CH-1:0] pending;
    int idx;
    assign pending = ch_read | ch_write;
    assign pmem_address = addr;
    assign pmem_wdata = wdata;
    // pick the winning channel: scan from rr_ptr (wrapping) or from channel 0
    always_comb begin
        sel = '0;
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (ARB_MODE == 1) ? i : (int'(rr_ptr) + i) % NUM_CH;
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel = IW'(idx);
            end
        end
    end
    // next state, downstream strobes and the completion pulse (suppressed while reset abandons the transaction)
    always_comb begin
        state_next = state;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        ch_resp = '0;
        ch_rdata = '0;
        if (state == IDLE) begin
            if (found) state_next = BUSY;
        end else begin
            pmem_read = !op;
            pmem_write = op;
            if (pmem_resp) begin
                state_next = IDLE;
                if (!rst) begin
                    ch_resp[grant] = 1'b1;
                    ch_rdata = pmem_rdata;
                end
            end
        end
    end
    // state, captured request and round-robin pointer; a simultaneous read+write is captured as a write
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= '0;
            op <= 1'b0;
            addr <= '0;
            wdata <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                grant <= sel;
                op <= ch_write[sel];
                addr <= ch_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata <= ch_wdata[int'(sel)*LINE_WIDTH +: LINE_WIDTH];
            end
            if (state == BUSY && pmem_resp && ARB_MODE == 0)
                rr_ptr <= (grant == IW'(NUM_CH - 1)) ? '0 : grant + IW'(1);
        end
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: scoreboard bench for a 4-channel round-robin and a 2-channel fixed-priority arbiter
module tb_pmem_arbiter;
    typedef struct {
        int           ch;
        logic [15:0]  addr;
        logic         wr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] rd = '0, wr = '0;
    logic [63:0] addr_in = '0;
    logic [511:0] wdata_in = '0;
    logic sel_fp = 1'b0, presp = 1'b0, auto = 1'b1;
    logic [127:0] prdata = '0, fill = '0;
    int lat = 3;
    logic [3:0] rr_resp;
    logic [1:0] fp_resp;
    logic [127:0] rr_rdata, fp_rdata, rr_pwd, fp_pwd, m_rdata, m_pwd;
    logic rr_pr, rr_pw, fp_pr, fp_pw, m_pr, m_pw;
    logic [15:0] rr_pa, fp_pa, m_pa;
    logic [3:0] m_resp;
    always #5 clk = ~clk;
    pmem_arbiter #(.NUM_CH(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .ch_read(sel_fp ? 4'b0 : rd), .ch_write(sel_fp ? 4'b0 : wr),
        .ch_address(sel_fp ? 64'b0 : addr_in), .ch_wdata(sel_fp ? 512'b0 : wdata_in),
        .ch_resp(rr_resp), .ch_rdata(rr_rdata),
        .pmem_read(rr_pr), .pmem_write(rr_pw), .pmem_address(rr_pa), .pmem_wdata(rr_pwd),
        .pmem_resp(presp & !sel_fp), .pmem_rdata(prdata)
    );
    pmem_arbiter #(.NUM_CH(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .ch_read(sel_fp ? rd[1:0] : 2'b0), .ch_write(sel_fp ? wr[1:0] : 2'b0),
        .ch_address(sel_fp ? addr_in[31:0] : 32'b0), .ch_wdata(sel_fp ? wdata_in[255:0] : 256'b0),
        .ch_resp(fp_resp), .ch_rdata(fp_rdata),
        .pmem_read(fp_pr), .pmem_write(fp_pw), .pmem_address(fp_pa), .pmem_wdata(fp_pwd),
        .pmem_resp(presp & sel_fp), .pmem_rdata(prdata)
    );
    assign m_resp = sel_fp ? {2'b0, fp_resp} : rr_resp;
    assign m_rdata = sel_fp ? fp_rdata : rr_rdata;
    assign m_pr = sel_fp ? fp_pr : rr_pr;
    assign m_pw = sel_fp ? fp_pw : rr_pw;
    assign m_pa = sel_fp ? fp_pa : rr_pa;
    assign m_pwd = sel_fp ? fp_pwd : rr_pwd;
    // downstream memory model: answers on the lat-th strobe cycle
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (auto) begin
                cnt = (m_pr || m_pw) ? cnt + 1 : 0;
                presp = (cnt == lat);
                prdata = presp ? fill : '0;
                if (presp) cnt = 0;
            end
        end
    end
    // scoreboard monitor: every completion pulse is matched against the oldest expected transaction
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (prev) begin
                checks++;
                if (m_pr || m_pw) begin
                    errors++;
                    $display("FAIL idle_gap strobes rd=%b wr=%b want 0 0", m_pr, m_pw);
                end
            end
            if (m_resp != 0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp got %b want none", m_resp);
                end else begin
                    e = q.pop_front();
                    if (m_resp !== 4'(1 << e.ch) || m_rdata !== e.rdata || m_pa !== e.addr ||
                        m_pw !== e.wr || m_pr !== !e.wr || (e.wr && m_pwd !== e.wdata)) begin
                        errors++;
                        $display("FAIL resp got resp=%b addr=%h wr=%b rdata=%h wdata=%h want ch=%0d addr=%h wr=%b rdata=%h wdata=%h",
                                 m_resp, m_pa, m_pw, m_rdata, m_pwd, e.ch, e.addr, e.wr, e.rdata, e.wdata);
                    end
                end
            end else begin
                checks++;
                if (m_rdata !== '0) begin
                    errors++;
                    $display("FAIL rdata_idle got %h want 0", m_rdata);
                end
            end
            prev = (m_resp != 0);
        end
    end
    task automatic push_exp(input int ch, input logic [15:0] a, input logic w, input logic [127:0] wd);
        exp_t e;
        e.ch = ch;
        e.addr = a;
        e.wr = w;
        e.wdata = wd;
        e.rdata = fill;
        q.push_back(e);
    endtask
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", q.size());
            q.delete();
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel_fp = s[0];
            #2;
            checks++;
            if ({m_pr, m_pw, m_resp} !== 6'b0 || m_pa !== '0 || m_pwd !== '0 || m_rdata !== '0) begin
                errors++;
                $display("FAIL reset_state got rd=%b wr=%b resp=%b addr=%h wdata=%h rdata=%h want all 0",
                         m_pr, m_pw, m_resp, m_pa, m_pwd, m_rdata);
            end
            @(negedge clk);
        end
        sel_fp = 1'b0;
        rst = 1'b0;
    endtask
    task automatic test_single_read();
        fill = {16{8'hA5}};
        lat = 3;
        @(negedge clk);
        addr_in[16 +: 16] = 16'h1230;
        rd[1] = 1'b1;
        push_exp(1, 16'h1230, 1'b0, '0);
        #1;
        checks++;
        if (m_pr !== 1'b0) begin
            errors++;
            $display("FAIL read_latency0 got %b want 0", m_pr);
        end
        @(negedge clk);
        #2;
        checks++;
        if (m_pr !== 1'b1 || m_pw !== 1'b0 || m_pa !== 16'h1230) begin
            errors++;
            $display("FAIL read_strobe got rd=%b wr=%b addr=%h want 1 0 1230", m_pr, m_pw, m_pa);
        end
        rd[1] = 1'b0;
        drain(20);
        @(negedge clk);
        #2;
        checks++;
        if (m_resp !== 4'b0) begin
            errors++;
            $display("FAIL resp_one_cycle got %b want 0", m_resp);
        end
    endtask
    task automatic test_round_robin();
        do_reset();
        lat = 2;
        fill = {4{32'h0BADF00D}};
        addr_in[0 +: 16] = 16'h1000;
        addr_in[16 +: 16] = 16'h2000;
        for (int i = 0; i < 4; i++) push_exp(i % 2, (i % 2) ? 16'h2000 : 16'h1000, 1'b0, '0);
        rd[1:0] = 2'b11;
        drain(60);
        rd = '0;
        repeat (3) @(negedge clk);
    endtask
    task automatic test_write();
        lat = 3;
        fill = {8{16'h5A3C}};
        @(negedge clk);
        addr_in[0 +: 16] = 16'h0040;
        wdata_in[0 +: 128] = 128'hDEADBEEF;
        wr[0] = 1'b1;
        push_exp(0, 16'h0040, 1'b1, 128'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            checks++;
            if (m_pr !== 1'b0 || m_pw !== 1'b1 || m_pwd !== 128'hDEADBEEF) begin
                errors++;
                $display("FAIL write_busy cyc=%0d got rd=%b wr=%b wdata=%h want 0 1 deadbeef", i, m_pr, m_pw, m_pwd);
            end
            if (i == 0) wr[0] = 1'b0;
        end
        drain(10);
        @(negedge clk);
        #2;
        checks++;
        if (m_pr !== 1'b0 || m_pw !== 1'b0) begin
            errors++;
            $display("FAIL write_after got rd=%b wr=%b want 0 0", m_pr, m_pw);
        end
    endtask
    task automatic test_read_write_both();
        lat = 2;
        @(negedge clk);
        addr_in[32 +: 16] = 16'h0300;
        wdata_in[256 +: 128] = {4{32'hC0FFEE11}};
        rd[2] = 1'b1;
        wr[2] = 1'b1;
        push_exp(2, 16'h0300, 1'b1, {4{32'hC0FFEE11}});
        @(negedge clk);
        rd[2] = 1'b0;
        wr[2] = 1'b0;
        drain(10);
        repeat (4) @(negedge clk);
    endtask
    task automatic test_wrap();
        lat = 2;
        fill = {2{64'h0123456789ABCDEF}};
        @(negedge clk);
        addr_in[0 +: 16] = 16'h0A00;
        addr_in[32 +: 16] = 16'h0C00;
        push_exp(0, 16'h0A00, 1'b0, '0);
        push_exp(2, 16'h0C00, 1'b0, '0);
        rd[0] = 1'b1;
        rd[2] = 1'b1;
        drain(30);
        rd = '0;
        repeat (3) @(negedge clk);
    endtask
    task automatic test_idle_resp();
        auto = 1'b0;
        @(negedge clk);
        presp = 1'b1;
        prdata = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            checks++;
            if (m_resp !== 4'b0 || m_pr !== 1'b0 || m_pw !== 1'b0) begin
                errors++;
                $display("FAIL idle_resp got resp=%b rd=%b wr=%b want 0 0 0", m_resp, m_pr, m_pw);
            end
        end
        presp = 1'b0;
        prdata = '0;
        auto = 1'b1;
    endtask
    task automatic test_reset_mid();
        lat = 2;
        @(negedge clk);
        addr_in[16 +: 16] = 16'h0555;
        rd[1] = 1'b1;
        @(negedge clk);
        #2;
        checks++;
        if (m_pr !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy got %b want 1", m_pr);
        end
        rd[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++;
        if (m_resp !== 4'b0 || presp !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_resp got resp=%b presp=%b want 0 1", m_resp, presp);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (m_pr !== 1'b0 || m_pw !== 1'b0 || m_pa !== '0) begin
            errors++;
            $display("FAIL rstmid_idle got rd=%b wr=%b addr=%h want 0 0 0", m_pr, m_pw, m_pa);
        end
        repeat (4) @(negedge clk);
    endtask
    task automatic test_fixed_priority();
        sel_fp = 1'b1;
        do_reset();
        lat = 2;
        fill = {16{8'h3C}};
        addr_in[0 +: 16] = 16'h0111;
        addr_in[16 +: 16] = 16'h0222;
        for (int i = 0; i < 3; i++) push_exp(0, 16'h0111, 1'b0, '0);
        rd[1:0] = 2'b11;
        drain(40);
        rd = '0;
        repeat (4) @(negedge clk);
        sel_fp = 1'b0;
    endtask
    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_read_write_both();
        test_wrap();
        test_idle_resp();
        test_reset_mid();
        test_fixed_priority();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end
endmodule
